// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the IF/MEM memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int DEF_MAX_DATA_RUN = 4;
  localparam int DEF_TIMEOUT      = 255;
  localparam int RUN_W            = 4;
  localparam int WD_W             = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - data-first priority pick with a run counter that forces a fetch grant
// after MAX_DATA_RUN consecutive data grants taken while fetch was waiting.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_RUN = DEF_MAX_DATA_RUN
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic grant_i,
  output logic winner_o
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  owner_e           winner;

  always_comb begin
    winner    = OWN_IF;
    run_cnt_d = run_cnt_q;
    if (dm_req_i && !(if_req_i && (run_cnt_q == RUN_MAX))) begin
      winner = OWN_DM;
    end
    // The run only counts data grants that actually made fetch wait.
    if (grant_i) begin
      if ((winner == OWN_DM) && if_req_i) begin
        run_cnt_d = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + 1'b1;
      end else begin
        run_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign winner_o = winner;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises IF and MEM stage accesses onto one variable-latency
// memory port, with per-stage stalls and a sticky watchdog timeout flag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = DEF_MAX_DATA_RUN,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              err_q, err_d;
  logic              grant;
  logic              winner;

  mem_arb_pick #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_pick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .if_req_i(if_req_i),
    .dm_req_i(dm_req_i),
    .grant_i (grant),
    .winner_o(winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wd_d        = wd_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    err_d       = err_q;
    grant       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && (if_req_i || dm_req_i)) begin
          grant     = 1'b1;
          owner_d   = owner_e'(winner);
          mem_req_d = 1'b1;
          wd_d      = '0;
          state_d   = ST_BUSY;
          if (owner_e'(winner) == OWN_DM) begin
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
          end
        end
      end

      ST_BUSY: begin
        // Ack is checked first so a same-cycle ack beats the watchdog.
        if (mem_ack_i || (wd_q == WD_LAST)) begin
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
          if (!mem_ack_i) begin
            err_d = 1'b1;
          end
          if (owner_q == OWN_DM) begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_ack_i ? mem_rdata_i : '0;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_ack_i ? mem_rdata_i : '0;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wd_q        <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wd_q        <= wd_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_ready_o  = dm_ready_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign stall_if_o  = if_req_i & ~if_ready_q;
  assign stall_mem_o = dm_req_i & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter with a latency-programmable
// memory responder; TIMEOUT=8, MAX_DATA_RUN=4.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ready_o;
  logic        stall_if_o;
  logic        stall_mem_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        err_o;

  logic        resp_ack;
  logic        man_ack;
  logic        ack_en;
  int          ack_lat;
  int          wcnt;
  logic        ack_fired;
  logic [31:0] rd_val;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  assign mem_ack_i = resp_ack | man_ack;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_DATA_RUN(4),
    .TIMEOUT     (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_ready_o (if_ready_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_rdata_o (dm_rdata_o),
    .dm_ready_o (dm_ready_o),
    .stall_if_o (stall_if_o),
    .stall_mem_o(stall_mem_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i  (mem_ack_i),
    .err_o      (err_o)
  );

  // Responder: acks ack_lat cycles after mem_req_o rises, updated away from the rising edge.
  initial begin
    resp_ack    = 1'b0;
    wcnt        = 0;
    ack_fired   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o && ack_en && !ack_fired) begin
        if (wcnt == ack_lat) begin
          resp_ack    = 1'b1;
          mem_rdata_i = rd_val;
          ack_fired   = 1'b1;
        end else begin
          wcnt = wcnt + 1;
        end
      end else begin
        resp_ack = 1'b0;
        if (!mem_req_o) begin
          wcnt      = 0;
          ack_fired = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i      = 1'b0;
    start_i    = 1'b0;
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    dm_req_i   = 1'b0;
    dm_we_i    = 1'b0;
    dm_addr_i  = '0;
    dm_wdata_i = '0;
    man_ack    = 1'b0;
    ack_en     = 1'b1;
    ack_lat    = 0;
    rd_val     = '0;

    tick();
    tick();
    check("rst_mem_req", mem_req_o, 0);
    check("rst_if_ready", if_ready_o, 0);
    check("rst_dm_ready", dm_ready_o, 0);
    check("rst_if_rdata", if_rdata_o, 0);
    check("rst_dm_rdata", dm_rdata_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_err", err_o, 0);
    rst_i   = 1'b1;
    start_i = 1'b1;
    tick();

    // Zero-wait load to give dm_rdata_o a known non-zero value.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20; rd_val = 32'h12345678; ack_lat = 0;
    tick();
    check("ld_mem_req", mem_req_o, 1);
    check("ld_mem_addr", mem_addr_o, 32'h20);
    tick();
    check("ld_ready", dm_ready_o, 1);
    check("ld_rdata", dm_rdata_o, 32'h12345678);
    dm_req_i = 1'b0;
    tick();

    // Zero-wait store: rdata must not follow mem_rdata_i.
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h10; dm_wdata_i = 32'hDEADBEEF;
    rd_val = 32'hFFFFFFFF;
    #1;
    check("st_c0_stall_mem", stall_mem_o, 1);
    check("st_c0_mem_req", mem_req_o, 0);
    tick();
    check("st_mem_req", mem_req_o, 1);
    check("st_mem_we", mem_we_o, 1);
    check("st_mem_addr", mem_addr_o, 32'h10);
    check("st_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    tick();
    check("st_ready", dm_ready_o, 1);
    check("st_rdata_kept", dm_rdata_o, 32'h12345678);
    check("st_stall_mem", stall_mem_o, 0);
    check("st_done_mem_req", mem_req_o, 0);
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    tick();

    // Single fetch, ack one cycle after mem_req_o rises: ready in cycle 3.
    if_req_i = 1'b1; if_addr_i = 32'h40; rd_val = 32'h8C020004; ack_lat = 1;
    #1;
    check("if_c0_stall", stall_if_o, 1);
    tick();
    check("if_c1_stall", stall_if_o, 1);
    check("if_c1_mem_req", mem_req_o, 1);
    check("if_c1_addr", mem_addr_o, 32'h40);
    check("if_c1_we", mem_we_o, 0);
    check("if_c1_wdata", mem_wdata_o, 0);
    tick();
    check("if_c2_stall", stall_if_o, 1);
    check("if_c2_ready", if_ready_o, 0);
    check("if_c2_mem_req", mem_req_o, 1);
    tick();
    check("if_c3_ready", if_ready_o, 1);
    check("if_c3_rdata", if_rdata_o, 32'h8C020004);
    check("if_c3_stall", stall_if_o, 0);
    if_req_i = 1'b0;
    tick();
    check("if_c4_ready", if_ready_o, 0);
    check("if_c4_mem_req", mem_req_o, 0);

    // Contention: grant order D,D,D,D,I repeating.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200; rd_val = 32'hA5A5A5A5; ack_lat = 0;
    for (int i = 0; i < 10; i++) begin
      logic exp_dm;
      exp_dm = ((i % 5) != 4);
      tick();
      check($sformatf("ct%0d_addr", i), mem_addr_o, exp_dm ? 32'h200 : 32'h100);
      tick();
      check($sformatf("ct%0d_dm_ready", i), dm_ready_o, exp_dm);
      check($sformatf("ct%0d_if_ready", i), if_ready_o, !exp_dm);
      check($sformatf("ct%0d_stall_if", i), stall_if_o, exp_dm);
      if (i == 9) begin
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
      end
      tick();
    end

    // Ack on the last permitted BUSY cycle beats the watchdog.
    dm_req_i = 1'b1; dm_addr_i = 32'h30; rd_val = 32'h0000BEEF; ack_lat = 7;
    for (int c = 1; c <= 8; c++) tick();
    check("tw_c8_mem_req", mem_req_o, 1);
    tick();
    check("tw_ready", dm_ready_o, 1);
    check("tw_rdata", dm_rdata_o, 32'h0000BEEF);
    check("tw_err", err_o, 0);
    dm_req_i = 1'b0;
    tick();

    // Never acked: 8 BUSY cycles, then ready with zero data and sticky err_o.
    dm_req_i = 1'b1; dm_addr_i = 32'h34; ack_en = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    check("to_c8_mem_req", mem_req_o, 1);
    check("to_c8_ready", dm_ready_o, 0);
    check("to_c8_err", err_o, 0);
    tick();
    check("to_ready", dm_ready_o, 1);
    check("to_rdata", dm_rdata_o, 0);
    check("to_err", err_o, 1);
    check("to_mem_req", mem_req_o, 0);
    dm_req_i = 1'b0;
    tick();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check("late_ack_mem_req", mem_req_o, 0);
    check("late_ack_dm_ready", dm_ready_o, 0);
    check("late_ack_if_ready", if_ready_o, 0);
    check("late_ack_err", err_o, 1);
    ack_en = 1'b1;

    // Start gating.
    start_i = 1'b0; if_req_i = 1'b1; dm_req_i = 1'b1; if_addr_i = 32'h50; dm_addr_i = 32'h60;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("sg%0d_mem_req", c), mem_req_o, 0);
      check($sformatf("sg%0d_stall_if", c), stall_if_o, 1);
      check($sformatf("sg%0d_stall_mem", c), stall_mem_o, 1);
    end
    start_i = 1'b1; ack_lat = 2; rd_val = 32'h00C0FFEE;
    tick();
    check("sg_busy_mem_req", mem_req_o, 1);
    check("sg_busy_addr", mem_addr_o, 32'h60);
    start_i = 1'b0;
    tick();
    tick();
    tick();
    check("sg_done_ready", dm_ready_o, 1);
    check("sg_done_rdata", dm_rdata_o, 32'h00C0FFEE);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("sg_post%0d_mem_req", c), mem_req_o, 0);
      check($sformatf("sg_post%0d_stall_mem", c), stall_mem_o, 1);
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    tick();

    // Reset asserted during BUSY, then a fresh grant of the still-pending fetch.
    start_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h44; ack_en = 1'b0;
    tick();
    tick();
    check("rm_busy_mem_req", mem_req_o, 1);
    rst_i = 1'b0;
    #1;
    check("rm_mem_req", mem_req_o, 0);
    check("rm_mem_addr", mem_addr_o, 0);
    check("rm_if_ready", if_ready_o, 0);
    check("rm_err", err_o, 0);
    check("rm_if_rdata", if_rdata_o, 0);
    tick();
    rst_i = 1'b1; ack_en = 1'b1; ack_lat = 0; rd_val = 32'h0BADF00D;
    tick();
    check("rm_regrant_mem_req", mem_req_o, 1);
    check("rm_regrant_addr", mem_addr_o, 32'h44);
    tick();
    check("rm_ready", if_ready_o, 1);
    check("rm_rdata", if_rdata_o, 32'h0BADF00D);
    if_req_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
